// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard controller for the 5-stage RISC-V core.
//
// Purpose:
//   - Combinational E-stage operand forwarding selects (M has priority over W).
//   - One-bubble stall for load-use hazards.
//   - D/E flush when a branch or jump is taken in E.
//   - IDLE/BUSY sequencer for a multi-cycle MUL/DIV op that occupies E. It
//     freezes F/D/E and bubbles M for MUL_LATENCY-1 cycles. It then pulses
//     MulDoneE in the last E cycle.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   Rs1D, Rs2D                sources of the instruction in D
//   Rs1E, Rs2E, RdE           sources and destination of the instruction in E
//   RdM, RdW                  destinations in M and W
//   RegWriteM, RegWriteW      M / W instruction writes the register file
//   ResultSrcE                E instruction is a load
//   PCSrcE                    branch/jump taken, resolved in E
//   MulStartE                 E holds a multi-cycle op (held while in E)
//   ForwardAE, ForwardBE      00 = regfile, 10 = ALUResultM, 01 = ResultW
//   StallF/StallD/StallE      hold PC, IF/ID, ID/EX
//   FlushD/FlushE/FlushM      clear IF/ID, ID/EX, EX/MEM
//   MulBusy                   sequencer is in BUSY
//   MulDoneE                  one-cycle pulse: multi-cycle result valid in E
//
// Optional feature (macro HAZARD_PERF_EN):
//   Adds StallCount[31:0] and FlushCount[31:0]. These are saturating
//   counters of the cycles with StallF high and with FlushD||FlushE high.

module hazard_sequencer #(
    parameter int MUL_LATENCY = 4,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MulStartE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MulBusy,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount,
`endif
    output logic              MulDoneE
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Loading MUL_LATENCY-2 gives MUL_LATENCY-1 stall cycles in total:
    // the start cycle in IDLE, plus one BUSY cycle for each count above 0.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 2);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    // High during the first cycle after reset. All control outputs stay
    // quiet in that cycle and the sequencer does not accept a start.
    logic       quiet_q;
    logic       load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            quiet_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quiet_q <= 1'b0;
        end
    end

    // Forwarding is independent of the sequencer state.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!rst) begin
            if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
                ForwardAE = 2'b01;
            if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end
    end

    assign load_use = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        MulBusy  = 1'b0;
        MulDoneE = 1'b0;
        if (!rst && !quiet_q) begin
            case (state_q)
                IDLE: begin
                    if (MulStartE) begin
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        StallE  = 1'b1;
                        FlushM  = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end else if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                BUSY: begin
                    // The op is still in E, so hazard inputs are ignored here.
                    MulBusy = 1'b1;
                    if (cnt_q != 4'd0) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                        cnt_d  = cnt_q - 4'd1;
                    end else begin
                        MulDoneE = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (StallF && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((FlushD || FlushE) && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (MUL_LATENCY = 4).
// Inputs change 1 time unit after each rising edge. Outputs are sampled
// 1 time unit later, well away from the next edge.
// ctl packs {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulBusy,MulDoneE}.

module tb_hazard_sequencer;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDoneE;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCount, FlushCount;
`endif
    logic [7:0] ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDoneE};

    localparam logic [7:0] CTL_NONE   = 8'b0000_0000;
    localparam logic [7:0] CTL_LDUSE  = 8'b1100_1000;
    localparam logic [7:0] CTL_BRANCH = 8'b0001_1000;
    localparam logic [7:0] CTL_MSTART = 8'b1110_0100;
    localparam logic [7:0] CTL_MBUSY  = 8'b1110_0110;
    localparam logic [7:0] CTL_MDONE  = 8'b0000_0011;

    hazard_sequencer #(.MUL_LATENCY(4), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MulBusy(MulBusy),
`ifdef HAZARD_PERF_EN
        .StallCount(StallCount), .FlushCount(FlushCount),
`endif
        .MulDoneE(MulDoneE)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic clear_inputs;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MulStartE = 0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();  // quiet cycle after reset
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        ResultSrcE = 1; RdE = 7; Rs1D = 7;
        RegWriteM = 1; RdM = 3; Rs1E = 3;
        step(); step();
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, CTL_NONE); end
        checks++;
        if (ForwardAE !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b exp 00", ForwardAE); end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin errors++; $display("FAIL post_reset_quiet got %b exp %b", ctl, CTL_NONE); end
        checks++;
        if (ForwardAE !== 2'b10) begin errors++; $display("FAIL post_reset_fwd got %b exp 10", ForwardAE); end
        step();
        #1;
        checks++;
        if (ctl !== CTL_LDUSE) begin errors++; $display("FAIL post_reset_lduse got %b exp %b", ctl, CTL_LDUSE); end
        clear_inputs();
    endtask

    task automatic test_forwarding;
        clear_inputs();
        step();
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
        Rs2E = 9;
        #1;
        checks++;
        if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_prio got %b exp 10", ForwardAE); end
        checks++;
        if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwd_b_none got %b exp 00", ForwardBE); end
        RegWriteM = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w got %b exp 01", ForwardAE); end
        RdW = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b exp 00", ForwardAE); end
        RdW = 9; RegWriteW = 1; RdM = 9; RegWriteM = 1;
        #1;
        checks++;
        if (ForwardBE !== 2'b10) begin errors++; $display("FAIL fwd_b_m got %b exp 10", ForwardBE); end
        RdM = 4;
        #1;
        checks++;
        if (ForwardBE !== 2'b01) begin errors++; $display("FAIL fwd_b_w got %b exp 01", ForwardBE); end
        clear_inputs();
    endtask

    task automatic test_load_use;
        clear_inputs();
        step();
        ResultSrcE = 1; RdE = 7; Rs2D = 7;
        #1;
        checks++;
        if (ctl !== CTL_LDUSE) begin errors++; $display("FAIL lduse got %b exp %b", ctl, CTL_LDUSE); end
        step();
        // the load advanced and a bubble now sits in E
        ResultSrcE = 0; RdE = 0;
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin errors++; $display("FAIL lduse_one_cycle got %b exp %b", ctl, CTL_NONE); end
        step();
        ResultSrcE = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin errors++; $display("FAIL lduse_x0 got %b exp %b", ctl, CTL_NONE); end
        clear_inputs();
    endtask

    task automatic test_branch_vs_load_use;
        clear_inputs();
        step();
        ResultSrcE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        #1;
        checks++;
        if (ctl !== CTL_BRANCH) begin errors++; $display("FAIL branch_prio got %b exp %b", ctl, CTL_BRANCH); end
        clear_inputs();
    endtask

    task automatic test_mul;
        clear_inputs();
        step();
        MulStartE = 1;                       // cycle T
        #1;
        checks++;
        if (ctl !== CTL_MSTART) begin errors++; $display("FAIL mul_t0 got %b exp %b", ctl, CTL_MSTART); end
        step();
        PCSrcE = 1;                          // T+1, must be ignored
        #1;
        checks++;
        if (ctl !== CTL_MBUSY) begin errors++; $display("FAIL mul_t1 got %b exp %b", ctl, CTL_MBUSY); end
        step();
        PCSrcE = 0;                          // T+2
        #1;
        checks++;
        if (ctl !== CTL_MBUSY) begin errors++; $display("FAIL mul_t2 got %b exp %b", ctl, CTL_MBUSY); end
        step();                              // T+3
        #1;
        checks++;
        if (ctl !== CTL_MDONE) begin errors++; $display("FAIL mul_t3 got %b exp %b", ctl, CTL_MDONE); end
        step();
        MulStartE = 0;                       // T+4, op left E
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin errors++; $display("FAIL mul_t4 got %b exp %b", ctl, CTL_NONE); end
        clear_inputs();
    endtask

    task automatic test_mul_reset;
        logic saw_done;
        saw_done = 1'b0;
        clear_inputs();
        step();
        MulStartE = 1;                       // T
        step();
        rst = 1'b1;                          // T+1
        RegWriteM = 1; RdM = 2; Rs1E = 2;
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin errors++; $display("FAIL mulrst_during got %b exp %b", ctl, CTL_NONE); end
        checks++;
        if (ForwardAE !== 2'b00) begin errors++; $display("FAIL mulrst_fwd got %b exp 00", ForwardAE); end
        step();
        rst = 1'b0; MulStartE = 0;           // T+2
        #1;
        checks++;
        if (ctl !== CTL_NONE) begin errors++; $display("FAIL mulrst_t2 got %b exp %b", ctl, CTL_NONE); end
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            if (MulDoneE !== 1'b0 || MulBusy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL mulrst_no_done got %b exp 0", saw_done); end
        clear_inputs();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf;
        clear_inputs();
        do_reset();
        checks++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            errors++; $display("FAIL perf_reset got %0d/%0d exp 0/0", StallCount, FlushCount);
        end
        MulStartE = 1;
        step(); step(); step();              // T+3 done cycle
        step();
        MulStartE = 0;
        ResultSrcE = 1; RdE = 6; Rs1D = 6;   // one load-use cycle
        step();
        clear_inputs();
        step();
        checks++;
        if (StallCount !== 32'd4) begin errors++; $display("FAIL perf_stall got %0d exp 4", StallCount); end
        checks++;
        if (FlushCount !== 32'd1) begin errors++; $display("FAIL perf_flush got %0d exp 1", FlushCount); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_vs_load_use();
        test_mul();
        test_mul_reset();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
